byte_reg_arbiter: RTL
=====================

// Module: byte_reg_arbiter
// PURPOSE
//  Shares one 16-bit byte-enabled storage register between N_REQ write requesters.
//  Round-robin arbitration over valid/ready handshakes; one write accepted per clock.
//  Optional per-requester lock gives back-to-back ownership, bounded by MAX_LOCK.
//  Sits between requester agents and the byte-enabled register they jointly update.
// PARAMETERS
//  N_REQ     3   number of requesters (2..8)
//  MAX_LOCK  4   max consecutive accepted writes per locked tenure (1..15)
//  IDW       2   requester-id width, = $clog2(N_REQ) (min 1)
// PORTS
//  clk          in   1          single clock, rising edge
//  resetn       in   1          asynchronous, active-low reset
//  req_valid    in   N_REQ      requester i has a write pending
//  req_ready    out  N_REQ      one-hot or zero; requester i granted this cycle
//  req_lock     in   N_REQ      requester i asks to keep ownership after this write
//  req_d        in   16*N_REQ   write data, requester i at [16*i +: 16]
//  req_byteena  in   2*N_REQ    byte enables, requester i at [2*i +: 2]; bit0=[7:0]
//  q            out  16         stored register value
//  wr_fire      out  1          registered pulse: a write landed in q this edge
//  wr_id        out  IDW        registered id of the writer that landed
//  lock_active  out  1          FSM is in LOCKED
// BEHAVIOUR
//  - Reset (resetn=0, async): q=0, wr_fire=0, wr_id=0, lock_active=0, ptr=0, FSM=IDLE, cnt=0.
//  - Transfer for i = req_valid[i] & req_ready[i]; at most one per cycle.
//  - req_ready is combinational from req_valid, ptr, FSM; never asserted without valid.
//  - IDLE: winner = first valid index scanning ptr, ptr+1, ... wrapping at N_REQ-1 -> 0.
//  - Transfer latency 1: next edge q[7:0]<=d[7:0] if be[0], q[15:8]<=d[15:8] if be[1];
//    unenabled bytes hold. be=2'b00 still a transfer (q unchanged, wr_fire=1).
//  - wr_fire/wr_id registered; high for exactly one cycle per transfer, aligned with q change.
//  - IDLE, transfer by w with req_lock[w]=0: ptr <= (w+1) mod N_REQ, stay IDLE.
//  - IDLE, transfer by w with req_lock[w]=1 and MAX_LOCK>1: -> LOCKED, owner=w, cnt=1.
//  - LOCKED: only owner may get ready (others 0 even if valid); ptr frozen.
//    owner transfer, lock=1, cnt+1<MAX_LOCK: stay, cnt++.
//    owner transfer with lock=0, or cnt+1==MAX_LOCK: -> IDLE, ptr=(owner+1) mod N_REQ, cnt=0.
//    owner valid=0 and lock=0: -> IDLE next edge, ptr=(owner+1) mod N_REQ, no write.
//    owner valid=0 and lock=1: stay LOCKED (idle bubble), cnt unchanged.
//  - MAX_LOCK=1: lock ignored, FSM never leaves IDLE.
//  - Requester may drop valid without transfer; no state change from ungranted requests.
//  - Reset asserted mid-tenure: immediate return to reset values; pending write discarded.
//  - lock_active = (FSM==LOCKED), registered.
// STRUCTURE
//  - Package byte_reg_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED}; localparam DATA_W=16,
//    BYTES=2; function rr_pick(valid, ptr) returning winner id + found flag.
//  - Sub-module byteen_reg16: 16-bit register with 2 byte enables + write strobe,
//    async active-low reset to 0; drives q.
//  - Top holds arbitration logic, ptr, FSM, owner, cnt, wr_fire/wr_id pipeline regs.
// TESTING  (N_REQ=3, MAX_LOCK=4)
//  1 Reset: hold valid=3'b111, d=16'hFFFF; pulse resetn low mid-cycle -> q=0, wr_fire=0
//    immediately, ready=0 during reset.
//  2 Round-robin: valid=3'b111 constant, lock=0 -> grants 0,1,2,0,1,2; wr_id follows one
//    cycle later; q equals last writer's d per byteena.
//  3 Byte enables: r0 d=16'hABCD be=11 -> q=ABCD; r1 d=16'h1234 be=01 -> q=AB34;
//    r2 d=16'h5678 be=10 -> q=5634; r0 be=00 -> q=5634, wr_fire=1.
//  4 Lock cap: r1 lock=1 valid=1 continuously, r0/r2 valid -> r1 gets 4 consecutive
//    grants, then r2, then r0; lock_active high exactly during tenure.
//  5 Lock release/bubble: r0 locks, drops valid with lock=1 two cycles -> no grants to
//    r1/r2; then lock=0,valid=0 -> IDLE, next grant r1.
//  6 Random: 400 cycles random valid/lock/d/byteena vs scoreboard model of q; zero mismatches,
//    at most one ready bit per cycle.

Source files
------------

// File: rtl/byte_reg_pkg.sv
// Shared types, widths and the round-robin pick helper for the byte register arbiter.
// No timing of its own; pure declarations and one combinational function.
// No flow control here; the arbiter top applies the results.
package byte_reg_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int DATA_W  = 16;
    localparam int BYTES   = 2;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] id;
    } rr_pick_t;

    // First set bit of valid, scanning from ptr upward and wrapping at n-1 -> 0.
    // valid is zero-padded above n; ptr must be below n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 n);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!r.found && (k < n) && valid[3'(idx)]) begin
                r.found = 1'b1;
                r.id    = 3'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_reg_arbiter_byteen_reg16.sv
// 16-bit storage register with per-byte write enables; bytes not enabled hold.
// Latency: one clock from wr_en to q.
// No backpressure: every strobed write is taken.
module byteen_reg16
    import byte_reg_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [BYTES-1:0]  be,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Byte-lane update on a strobed write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) begin
                    q[8*b +: 8] <= d[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/byte_reg_arbiter.sv
// Round-robin arbiter sharing one byte-enabled 16-bit register, with bounded lock tenures.
// Latency: one clock from accepted handshake to q update and wr_fire/wr_id pulse.
// Backpressure: req_ready is at most one-hot; in a lock only the owner can be ready.
module byte_reg_arbiter
    import byte_reg_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int MAX_LOCK = 4,
    parameter int IDW      = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_lock,
    input  logic [DATA_W*N_REQ-1:0] req_d,
    input  logic [BYTES*N_REQ-1:0]  req_byteena,
    output logic [DATA_W-1:0]       q,
    output logic                    wr_fire,
    output logic [IDW-1:0]          wr_id,
    output logic                    lock_active
);

    arb_state_t        state, state_n;
    logic [IDW-1:0]    ptr, ptr_n;
    logic [IDW-1:0]    owner, owner_n;
    logic [3:0]        cnt, cnt_n;

    logic [MAX_REQ-1:0] valid8;
    rr_pick_t           pick;
    logic [IDW-1:0]     grant_id;
    logic               fire;
    logic [DATA_W-1:0]  wd;
    logic [BYTES-1:0]   wbe;

    // Successor of a requester id, wrapping at the last requester.
    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] w);
        return (int'(w) == N_REQ - 1) ? '0 : w + 1'b1;
    endfunction

    // Round-robin candidate from the current pointer.
    always_comb begin
        valid8              = '0;
        valid8[N_REQ-1:0]   = req_valid;
        pick                = rr_pick(valid8, 3'(ptr), N_REQ);
    end

    // Grant selection; ready is forced low while reset is held.
    always_comb begin
        req_ready = '0;
        grant_id  = ptr;
        if (state == ARB_IDLE) begin
            grant_id = pick.id[IDW-1:0];
            if (pick.found) begin
                req_ready[grant_id] = resetn;
            end
        end else begin
            grant_id = owner;
            if (req_valid[owner]) begin
                req_ready[owner] = resetn;
            end
        end
    end

    // Write data / byte enable mux from the granted requester.
    always_comb begin
        wd  = '0;
        wbe = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                wd  = req_d[DATA_W*i +: DATA_W];
                wbe = req_byteena[BYTES*i +: BYTES];
            end
        end
        fire = |(req_valid & req_ready);
    end

    // Next-state: lock entry, tenure counting, release and pointer advance.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        if (state == ARB_IDLE) begin
            if (fire) begin
                if (req_lock[grant_id] && (MAX_LOCK > 1)) begin
                    state_n = ARB_LOCKED;
                    owner_n = grant_id;
                    cnt_n   = 4'd1;
                end else begin
                    ptr_n = next_id(grant_id);
                end
            end
        end else begin
            if (fire) begin
                if (req_lock[owner] && ((int'(cnt) + 1) < MAX_LOCK)) begin
                    cnt_n = cnt + 4'd1;
                end else begin
                    state_n = ARB_IDLE;
                    ptr_n   = next_id(owner);
                    cnt_n   = '0;
                end
            end else if (!req_lock[owner]) begin
                state_n = ARB_IDLE;
                ptr_n   = next_id(owner);
                cnt_n   = '0;
            end
        end
    end

    // Arbitration state and write-report registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ARB_IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            wr_fire     <= 1'b0;
            wr_id       <= '0;
            lock_active <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            cnt         <= cnt_n;
            wr_fire     <= fire;
            lock_active <= (state_n == ARB_LOCKED);
            if (fire) begin
                wr_id <= grant_id;
            end
        end
    end

    byteen_reg16 u_reg (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (fire),
        .be     (wbe),
        .d      (wd),
        .q      (q)
    );

endmodule
